oser_tx: RTL and testbench
==========================

Name: oser_tx

Overview:
Single-clock parallel-to-serial output transmitter. It is the output-direction counterpart of the team's capture and latch primitives, and is Verilator-compatible for Gowin-flavoured simulation. It accepts a WIDTH-bit word through a valid/ready handshake, then drives the word onto a single registered serial output, one bit per CLK. Back-to-back words are supported, so a stream has no gap cycles.

Parameters:
WIDTH, 4, word width in bits; legal range 2..16; any other value is a compile-time error.
INIT, 1'b0, level driven on Q while idle and after reset.
LSB_FIRST, 1, 1 = D[0] is sent first; 0 = D[WIDTH-1] is sent first.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESETN  input  1  asynchronous active-low reset.
D  input  WIDTH  parallel word; sampled only on the accept edge.
LOAD  input  1  word-valid request.
READY  output  1  block can accept a word this cycle (combinational).
Q  output  1  serial data (registered).
Q_VLD  output  1  Q carries a valid data bit (registered).
LAST  output  1  Q currently carries the final bit of a word (registered).

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RESETN).
- Reset values while RESETN=0, applied immediately without waiting for CLK:
  - Q=INIT, Q_VLD=0, LAST=0.
  - state=IDLE, bit counter=0, shift register=0.
  - READY therefore reads 1.
- Reset release: RESETN deassertion is assumed synchronous to CLK. The first edge after release behaves as a normal IDLE edge.
- States: IDLE and SHIFT.
- READY = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1).
- Accept: rising edge with LOAD=1 & READY=1. On that edge:
  - Q <= first bit of D (per LSB_FIRST); the remaining WIDTH-1 bits go into the shift register.
  - cnt <= 0, Q_VLD <= 1, LAST <= 0, state <= SHIFT.
- Latency: the first bit appears on Q the cycle after the accept edge. A word occupies exactly WIDTH consecutive cycles on Q.
- SHIFT with cnt < WIDTH-1: each edge Q <= next bit, cnt <= cnt+1. LAST <= 1 on the edge where cnt becomes WIDTH-1.
- SHIFT with cnt == WIDTH-1 (last bit on Q, LAST=1, READY=1):
  - if LOAD=1: accept the new word as above (seamless, Q_VLD stays 1, LAST drops to 0);
  - else: Q <= INIT, Q_VLD <= 0, LAST <= 0, state <= IDLE.
- LOAD=1 while READY=0 is ignored. There is no queueing and D is not sampled. The word in flight is unaffected.
- LOAD in IDLE with D changing the following cycle: only the accept-edge value of D is transmitted.
- Reset mid-word: the word is aborted at once with reset values. It is not resumed, and no partial bits follow release.
- LAST is high for exactly one cycle per word and always coincides with Q_VLD=1.
- Counter width is clog2(WIDTH). There is no wrap-around beyond WIDTH-1, because the counter is reloaded on accept or the block returns to IDLE.
- No combinational path from D to Q. The only combinational output is READY, a function of state and cnt.

Test Plan:
1. Single word (WIDTH=4, INIT=0, LSB_FIRST=1): reset, then LOAD=1 with D=4'b1011 for one cycle.
   -> Q = 1,1,0,1 on cycles 1..4 after accept, Q_VLD=1 on those cycles, LAST=1 on cycle 4 only.
   -> Cycle 5: Q=0, Q_VLD=0, READY=1.
2. Back-to-back: accept D=4'hA, hold LOAD=1 and present D=4'h5 when READY rises on the last bit.
   -> Q = 0,1,0,1,1,0,1,0 over 8 contiguous cycles; Q_VLD never drops; LAST high on cycles 4 and 8.
3. Busy rejection: accept D=4'hF, then pulse LOAD with D=4'h0 on cycle 2.
   -> READY=0 on that cycle, Q = 1,1,1,1, then idle; 4'h0 is never sent.
4. MSB-first with idle-high (LSB_FIRST=0, INIT=1): D=4'b0010.
   -> Q = 0,0,1,0, then Q=1 idle; after reset Q=1 immediately.
5. Asynchronous reset mid-word: accept D=4'b0110, assert RESETN=0 between edges during bit 2.
   -> Q=INIT, Q_VLD=0, LAST=0 before the next CLK edge; after release READY=1 and Q stays INIT until a new LOAD.
6. WIDTH=16 sweep: send 16'h8001 then 16'h7FFE back-to-back.
   -> 32 contiguous valid bits in the correct order, LAST on cycles 16 and 32.
   -> Checked against a scoreboard model.

Source files
------------

// File: rtl/oser_tx.sv
// -----------------------------------------------------------------------------
// oser_tx - single-clock parallel-to-serial output transmitter.
//
// A WIDTH-bit word is accepted through a LOAD/READY handshake and driven out on
// a registered serial line, one bit per CLK. READY rises again while the final
// bit of a word is on Q, so a new word can follow with no gap cycle.
//
// Parameters:
//   WIDTH      word width in bits (2..16)
//   INIT       level driven on Q while idle and during/after reset
//   LSB_FIRST  1: D[0] leaves first, 0: D[WIDTH-1] leaves first
//
// Ports:
//   CLK     in   clock, rising edge
//   RESETN  in   asynchronous active-low reset
//   D       in   parallel word, sampled only on the accept edge
//   LOAD    in   word-valid request
//   READY   out  word can be accepted this cycle (combinational)
//   Q       out  serial data (registered)
//   Q_VLD   out  Q carries a valid data bit (registered)
//   LAST    out  Q carries the final bit of a word (registered)
// -----------------------------------------------------------------------------
module oser_tx #(
   parameter int unsigned WIDTH     = 4,
   parameter logic        INIT      = 1'b0,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD,
   output logic             READY,
   output logic             Q,
   output logic             Q_VLD,
   output logic             LAST
);

   // Guarded so an illegal WIDTH reports only the range error below.
   localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PEN = CW'(WIDTH - 2);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if ((WIDTH < 2) || (WIDTH > 16)) begin : g_width_check
      $error("oser_tx: WIDTH must lie in 2..16");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-2:0] sr_q;     // remaining bits, next-to-send at index 0
   logic             q_q;
   logic             vld_q;
   logic             last_q;

   logic [WIDTH-1:0] word_ord_s;
   logic             ready_s;
   logic             accept_s;

   // Reorders a word so that index 0 is always the first bit on the wire.
   function automatic logic [WIDTH-1:0] tx_order(input logic [WIDTH-1:0] word);
      logic [WIDTH-1:0] r;
      r = word;
      if (!LSB_FIRST) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = word[int'(WIDTH) - 1 - i];
         end
      end else begin
         r = word;
      end
      return r;
   endfunction

   // Handshake decode: ready in IDLE or while the final bit is being driven.
   always_comb begin
      word_ord_s = tx_order(D);
      ready_s    = 1'b0;
      if (state_q == ST_IDLE) begin
         ready_s = 1'b1;
      end else if ((state_q == ST_SHIFT) && (cnt_q == CNT_MAX)) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
      accept_s = LOAD & ready_s;
   end

   // Transmit FSM with registered serial outputs.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         sr_q    <= {(WIDTH-1){1'b0}};
         q_q     <= INIT;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= {CW{1'b0}};
                  sr_q    <= word_ord_s[WIDTH-1:1];
                  q_q     <= word_ord_s[0];
                  vld_q   <= 1'b1;
                  last_q  <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
                  q_q     <= INIT;
                  vld_q   <= 1'b0;
                  last_q  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (cnt_q != CNT_MAX) begin
                  // Mid-word: advance one bit; flag LAST as the final bit lands.
                  q_q     <= sr_q[0];
                  sr_q    <= sr_q >> 1'b1;
                  cnt_q   <= cnt_q + CNT_ONE;
                  vld_q   <= 1'b1;
                  last_q  <= (cnt_q == CNT_PEN);
               end else if (accept_s) begin
                  // Seamless follow-on word: Q_VLD stays high.
                  state_q <= ST_SHIFT;
                  cnt_q   <= {CW{1'b0}};
                  sr_q    <= word_ord_s[WIDTH-1:1];
                  q_q     <= word_ord_s[0];
                  vld_q   <= 1'b1;
                  last_q  <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
                  q_q     <= INIT;
                  vld_q   <= 1'b0;
                  last_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= {CW{1'b0}};
               sr_q    <= {(WIDTH-1){1'b0}};
               q_q     <= INIT;
               vld_q   <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign READY = ready_s;
   assign Q     = q_q;
   assign Q_VLD = vld_q;
   assign LAST  = last_q;

endmodule

// File: tb/tb_oser_tx.sv
// -----------------------------------------------------------------------------
// tb_oser_tx - scoreboard bench for oser_tx.
// Three instances: A (WIDTH=4, INIT=0, LSB first), B (WIDTH=4, INIT=1, MSB
// first) and C (WIDTH=16, INIT=0, LSB first). The driver pushes the expected
// serial bits of every word it knows will be accepted; an independent monitor
// pops one entry per valid output bit and checks idle levels otherwise.
// -----------------------------------------------------------------------------
module tb_oser_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  load;
   logic [3:0]  d_a;
   logic [3:0]  d_b;
   logic [15:0] d_c;
   logic [2:0]  rdy;
   logic [2:0]  q;
   logic [2:0]  vld;
   logic [2:0]  last;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] idx;
      logic       bit_v;
      logic       last_v;
   } exp_t;

   exp_t sb[$];

   localparam logic [2:0] INIT_V = 3'b010;

   oser_tx #(.WIDTH(4), .INIT(1'b0), .LSB_FIRST(1'b1)) dut_a (
      .CLK(clk), .RESETN(rst_n), .D(d_a), .LOAD(load[0]),
      .READY(rdy[0]), .Q(q[0]), .Q_VLD(vld[0]), .LAST(last[0])
   );

   oser_tx #(.WIDTH(4), .INIT(1'b1), .LSB_FIRST(1'b0)) dut_b (
      .CLK(clk), .RESETN(rst_n), .D(d_b), .LOAD(load[1]),
      .READY(rdy[1]), .Q(q[1]), .Q_VLD(vld[1]), .LAST(last[1])
   );

   oser_tx #(.WIDTH(16), .INIT(1'b0), .LSB_FIRST(1'b1)) dut_c (
      .CLK(clk), .RESETN(rst_n), .D(d_c), .LOAD(load[2]),
      .READY(rdy[2]), .Q(q[2]), .Q_VLD(vld[2]), .LAST(last[2])
   );

   // Monitor: one comparison per instance per cycle, sampled on the falling edge.
   initial begin : monitor
      exp_t       e;
      logic [2:0] prev_vld;
      prev_vld = 3'b000;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (vld[i] === 1'b1) begin
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_bit dut%0d: got Q=%b LAST=%b, scoreboard empty", i, q[i], last[i]);
               end else begin
                  e = sb.pop_front();
                  if ((e.idx != 2'(i)) || (e.bit_v !== q[i]) || (e.last_v !== last[i])) begin
                     errors++;
                     $display("FAIL serial_bit dut%0d: got Q=%b LAST=%b, expected dut%0d Q=%b LAST=%b",
                              i, q[i], last[i], e.idx, e.bit_v, e.last_v);
                  end
               end
            end else begin
               if ((q[i] !== INIT_V[i]) || (last[i] !== 1'b0) || (vld[i] !== 1'b0)) begin
                  errors++;
                  $display("FAIL idle_level dut%0d: got Q=%b Q_VLD=%b LAST=%b, expected Q=%b Q_VLD=0 LAST=0",
                           i, q[i], vld[i], last[i], INIT_V[i]);
               end else if (prev_vld[i] && (sb.size() != 0) && (sb[0].idx == 2'(i))) begin
                  errors++;
                  $display("FAIL stream_gap dut%0d: got Q_VLD=0 mid-stream, expected Q_VLD=1", i);
               end
            end
            prev_vld[i] = vld[i];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected wire order of one word.
   task automatic push_word(input logic [1:0] idx, input int w, input bit lsb, input logic [15:0] data);
      exp_t e;
      for (int k = 0; k < w; k++) begin
         e.idx    = idx;
         e.bit_v  = lsb ? data[k] : data[w - 1 - k];
         e.last_v = (k == w - 1);
         sb.push_back(e);
      end
   endtask

   initial begin : stimulus
      rst_n = 1'b1;
      load  = 3'b000;
      d_a   = 4'h0;
      d_b   = 4'h0;
      d_c   = 16'h0000;
      #1 rst_n = 1'b0;
      #1;
      // Reset values before any clock edge.
      chk("reset_q",     {13'd0, q},    {13'd0, INIT_V});
      chk("reset_vld",   {13'd0, vld},  16'h0000);
      chk("reset_last",  {13'd0, last}, 16'h0000);
      chk("reset_ready", {13'd0, rdy},  16'h0007);
      tick();
      tick();
      rst_n = 1'b1;
      ticks(2);
      chk("idle_ready", {13'd0, rdy}, 16'h0007);

      // 1: single word 4'b1011 -> 1,1,0,1.
      d_a = 4'b1011; load[0] = 1'b1;
      push_word(2'd0, 4, 1'b1, 16'h000B);
      tick();
      load[0] = 1'b0; d_a = 4'h0;
      chk("t1_ready_busy", {15'd0, rdy[0]}, 16'h0000);
      ticks(3);
      chk("t1_ready_last", {15'd0, rdy[0]}, 16'h0001);
      tick();
      chk("t1_c5_vld",   {15'd0, vld[0]}, 16'h0000);
      chk("t1_c5_q",     {15'd0, q[0]},   16'h0000);
      chk("t1_c5_ready", {15'd0, rdy[0]}, 16'h0001);
      ticks(2);

      // 2: back-to-back 4'hA then 4'h5, LOAD held high throughout.
      d_a = 4'hA; load[0] = 1'b1;
      push_word(2'd0, 4, 1'b1, 16'h000A);
      tick();
      d_a = 4'h5;
      push_word(2'd0, 4, 1'b1, 16'h0005);
      ticks(3);
      chk("t2_ready_last", {15'd0, rdy[0]}, 16'h0001);
      tick();
      load[0] = 1'b0; d_a = 4'h0;
      ticks(6);

      // 3: busy rejection, 4'h0 offered on cycle 2 must be ignored.
      d_a = 4'hF; load[0] = 1'b1;
      push_word(2'd0, 4, 1'b1, 16'h000F);
      tick();
      load[0] = 1'b0;
      tick();
      d_a = 4'h0; load[0] = 1'b1;
      chk("t3_ready_busy", {15'd0, rdy[0]}, 16'h0000);
      tick();
      load[0] = 1'b0;
      ticks(5);

      // 4: MSB first, idle high, 4'b0010 -> 0,0,1,0.
      d_b = 4'b0010; load[1] = 1'b1;
      push_word(2'd1, 4, 1'b0, 16'h0002);
      tick();
      load[1] = 1'b0; d_b = 4'hF;
      ticks(6);
      chk("t4_idle_q", {15'd0, q[1]}, 16'h0001);

      // 5: asynchronous reset while bit 2 of 4'b0110 is on Q.
      d_a = 4'b0110; load[0] = 1'b1;
      push_word(2'd0, 4, 1'b1, 16'h0006);
      tick();
      load[0] = 1'b0;
      tick();
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_q",     {15'd0, q[0]},    16'h0000);
      chk("t5_rst_vld",   {15'd0, vld[0]},  16'h0000);
      chk("t5_rst_last",  {15'd0, last[0]}, 16'h0000);
      chk("t5_rst_ready", {15'd0, rdy[0]},  16'h0001);
      tick();
      rst_n = 1'b1;
      ticks(6);
      chk("t5_post_ready", {15'd0, rdy[0]}, 16'h0001);

      // 6: WIDTH=16, 16'h8001 then 16'h7FFE back-to-back.
      d_c = 16'h8001; load[2] = 1'b1;
      push_word(2'd2, 16, 1'b1, 16'h8001);
      tick();
      d_c = 16'h7FFE;
      push_word(2'd2, 16, 1'b1, 16'h7FFE);
      chk("t6_ready_busy", {15'd0, rdy[2]}, 16'h0000);
      ticks(15);
      chk("t6_ready_last", {15'd0, rdy[2]}, 16'h0001);
      tick();
      load[2] = 1'b0; d_c = 16'h0000;
      ticks(20);

      chk("sb_drained", 16'(sb.size()), 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
